instr_mem_resp: RTL

INSTR_MEM_RESP -- requirements
Module: instr_mem_resp

---
 rtl/instr_mem_resp.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_resp.sv
// instr_mem_resp
// Single-port-style instruction memory serving a fetch stage, with a program
// load write port. After reset the whole array is filled with NOP_WORD, one
// word per cycle; only then are fetches served from memory and loads accepted.
//
// Parameters
//   DEPTH     number of 32-bit words (power of two, 16..65536)
//   BASE_ADDR byte address of word 0
//   NOP_WORD  fill word, also returned for fetches that cannot be served
//
// Ports
//   clk_i           clock, all state on the rising edge
//   rst_ni          asynchronous active-low reset
//   fetch_enable_i  fetch strobe; when low the fetch outputs hold
//   instr_addr_i    fetch byte address
//   instr_rdata_o   registered instruction word (1-cycle latency)
//   addr_err_o      registered: instr_rdata_o came from a bad address
//   load_en_i       program-load write strobe
//   load_addr_i     program-load byte address
//   load_data_i     program-load write data
//   load_ready_o    high when a load write can be accepted (READY state)
//   load_err_o      one-cycle pulse: a load write in READY was dropped
//   init_done_o     high once the fill is complete and fetches are served
//
// Handshake: a load write transfers on a rising edge where load_en_i=1 and
// load_ready_o=1 and the address is in range; there is no backpressure on the
// fetch side, fetch_enable_i=1 at an edge always produces a response after it.

module instr_mem_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        addr_err_o,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic        load_ready_o,
  output logic        load_err_o,
  output logic        init_done_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH) << 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          aerr_q, aerr_d;
  logic          lerr_q, lerr_d;

  logic [31:0]   mem_q [DEPTH];

  // Address decode. The offset compare is done on the unwrapped difference,
  // and addr >= BASE_ADDR is checked separately, so an address below the
  // base can never alias into the window through 32-bit wrap-around.
  logic [31:0]   fetch_off, load_off;
  logic          fetch_ok, load_ok;
  logic [AW-1:0] fetch_idx, load_idx;
  logic          load_we;

  assign fetch_off = instr_addr_i - BASE_ADDR;
  assign load_off  = load_addr_i - BASE_ADDR;
  assign fetch_ok  = (instr_addr_i[1:0] == 2'b00) && (instr_addr_i >= BASE_ADDR)
                     && (fetch_off < SPAN);
  assign load_ok   = (load_addr_i[1:0] == 2'b00) && (load_addr_i >= BASE_ADDR)
                     && (load_off < SPAN);
  assign fetch_idx = fetch_off[AW+1:2];
  assign load_idx  = load_off[AW+1:2];

  assign load_we = load_en_i && (state_q == ST_READY) && load_ok;

  // FSM next state: INIT walks the fill counter once, READY is terminal.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Response next values. The memory is read combinationally here and the
  // result registered, so a same-edge load to the same word returns the old
  // contents (read-before-write).
  always_comb begin
    rdata_d = rdata_q;
    aerr_d  = aerr_q;
    if (fetch_enable_i) begin
      if (state_q != ST_READY) begin
        rdata_d = NOP_WORD;
        aerr_d  = 1'b0;
      end else if (fetch_ok) begin
        rdata_d = mem_q[fetch_idx];
        aerr_d  = 1'b0;
      end else begin
        rdata_d = NOP_WORD;
        aerr_d  = 1'b1;
      end
    end
    lerr_d = load_en_i && (state_q == ST_READY) && !load_ok;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      rdata_q <= NOP_WORD;
      aerr_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      aerr_q  <= aerr_d;
      lerr_q  <= lerr_d;
    end
  end

  // Storage has no reset; the INIT walk is what clears it.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= NOP_WORD;
    end else if (load_we) begin
      mem_q[load_idx] <= load_data_i;
    end
  end

  assign instr_rdata_o = rdata_q;
  assign addr_err_o    = aerr_q;
  assign load_err_o    = lerr_q;
  assign init_done_o   = (state_q == ST_READY);
  assign load_ready_o  = (state_q == ST_READY);

endmodule
